// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared defaults and helpers for the instruction fetch queue
package inst_fetch_queue_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int ILEN_DEFAULT = 32;

   // addi x0, x0, 0 -- what decode substitutes while out_valid is low
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Index bits plus one wrap bit, so full and empty stay distinguishable
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ifq_ptr.sv
// rtl/ifq_ptr.sv - wrap-bit FIFO pointer with increment, flush load and full/empty compare
module ifq_ptr
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          load,
   input  logic [PW-1:0] load_val,
   input  logic [PW-1:0] other,
   output logic [PW-1:0] ptr,
   output logic          same,
   output logic          wrapped
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

   // Same index with opposite wrap bits means the writer is one lap ahead
   assign same    = (ptr == other);
   assign wrapped = (ptr[PW-2:0] == other[PW-2:0]) && (ptr[PW-1] != other[PW-1]);

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch-to-decode {pc, inst} FIFO with redirect flush; RVSEED_IFQ_BYPASS_EN adds empty-queue pass-through
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int ILEN  = ILEN_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [ILEN-1:0]        in_inst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [ILEN-1:0]        out_inst,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [ILEN-1:0] inst_mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_same, wr_wrapped;
   logic          rd_same, rd_wrapped;
   logic          empty, full;
   logic          push, pop;

   // Both instances compare the same pair, so either result is valid
   assign empty    = wr_same & rd_same;
   assign full     = wr_wrapped | rd_wrapped;
   assign in_ready = !full;
   assign pop      = !empty && out_ready && !flush;

`ifdef RVSEED_IFQ_BYPASS_EN
   // An entry consumed straight through an empty queue never touches storage
   assign push = in_valid && in_ready && !flush && !(empty && out_ready);

   always_comb begin
      out_valid = 1'b0;
      out_pc    = '0;
      out_inst  = '0;
      if (!empty) begin
         out_valid = 1'b1;
         out_pc    = pc_mem[rd_ptr[AW-1:0]];
         out_inst  = inst_mem[rd_ptr[AW-1:0]];
      end else if (!flush && in_valid) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_inst  = in_inst;
      end
   end
`else
   assign push = in_valid && in_ready && !flush;

   // Storage survives a flush, so an empty queue must mask the stale head
   always_comb begin
      out_valid = 1'b0;
      out_pc    = '0;
      out_inst  = '0;
      if (!empty) begin
         out_valid = 1'b1;
         out_pc    = pc_mem[rd_ptr[AW-1:0]];
         out_inst  = inst_mem[rd_ptr[AW-1:0]];
      end
   end
`endif

   ifq_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
      .clk      (clk),
      .rst      (rst),
      .inc      (push),
      .load     (flush),
      .load_val (rd_ptr),
      .other    (rd_ptr),
      .ptr      (wr_ptr),
      .same     (wr_same),
      .wrapped  (wr_wrapped)
   );

   ifq_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .inc      (pop),
      .load     (flush),
      .load_val (rd_ptr),
      .other    (wr_ptr),
      .ptr      (rd_ptr),
      .same     (rd_same),
      .wrapped  (rd_wrapped)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr[AW-1:0]]   <= in_pc;
         inst_mem[wr_ptr[AW-1:0]] <= in_inst;
      end
   end

   assign count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized self-checking bench for inst_fetch_queue against a queue model
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [2:0]  count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   wire [68:0] obs = {out_valid, in_ready, count, out_pc, out_inst};

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .ILEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
   );

   function automatic logic [68:0] exp_vec();
      logic        ev  = 1'b0;
      logic [31:0] epc = 32'h0;
      logic [31:0] ein = 32'h0;
      int          sz  = q.size();
      logic [2:0]  cnt = sz[2:0];
      if (sz > 0) begin
         ev  = 1'b1;
         epc = q[0].pc;
         ein = q[0].inst;
      end
`ifdef RVSEED_IFQ_BYPASS_EN
      else if (!flush && in_valid) begin
         ev  = 1'b1;
         epc = in_pc;
         ein = in_inst;
      end
`endif
      return {ev, (sz < DEPTH), cnt, epc, ein};
   endfunction

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Advance one clock, applying the FIFO rules to the model queue
   task automatic tick();
      int   sz      = q.size();
      logic do_push = 1'b0;
      logic do_pop  = 1'b0;
      logic do_fl   = flush;
      ent_t e;
      e.pc   = in_pc;
      e.inst = in_inst;
      if (!flush) begin
         do_pop  = (sz > 0) && out_ready;
         do_push = in_valid && (sz < DEPTH);
`ifdef RVSEED_IFQ_BYPASS_EN
         if (sz == 0 && out_ready) do_push = 1'b0;
`endif
      end
      @(posedge clk);
      if (do_fl) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [68:0] e;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      e = exp_vec();
      n_checks++;
      if (obs !== e) $display("FAIL reset obs=%h exp=%h", obs, e);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [31:0] insts [5] = '{32'h00000013, 32'h00500093, 32'h00108113, 32'h002081B3, 32'h0};
      logic [68:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(i * 4), insts[i], 1'b0, 1'b0);
         #1;
         e = exp_vec();
         n_checks++;
         if (obs !== e) $display("FAIL fill[%0d] obs=%h exp=%h", i, obs, e);
         else n_pass++;
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) $display("FAIL full count=%0d in_ready=%b exp 4/0", count, in_ready);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         #1;
         e = exp_vec();
         n_checks++;
         if (obs !== e) $display("FAIL drain[%0d] obs=%h exp=%h", i, obs, e);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [68:0] e;
      for (int i = 0; i < 22; i++) begin
         drive((i < 20), 32'h100 + 32'(i * 4), $urandom, 1'b1, 1'b0);
         #1;
         e = exp_vec();
         n_checks++;
         if (obs !== e) $display("FAIL stream[%0d] obs=%h exp=%h", i, obs, e);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_flush();
      logic [68:0] e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h20 + 32'(i * 4), $urandom, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h40, 32'h00000013, 1'b0, 1'b1);
      #1;
      e = exp_vec();
      n_checks++;
      if (obs !== e) $display("FAIL flush_cycle obs=%h exp=%h", obs, e);
      else n_pass++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         #1;
         e = exp_vec();
         n_checks++;
         if (obs !== e || out_pc === 32'h40) $display("FAIL post_flush[%0d] obs=%h exp=%h", i, obs, e);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_async_reset();
      logic [68:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      n_checks++;
      if (obs !== {1'b0, 1'b1, 3'd0, 64'd0}) $display("FAIL async_reset obs=%h exp=%h", obs, {1'b0, 1'b1, 3'd0, 64'd0});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h200, 32'h00500093, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      e = exp_vec();
      n_checks++;
      if (obs !== e || count !== 3'd1 || out_pc !== 32'h200) $display("FAIL after_reset obs=%h exp=%h", obs, e);
      else n_pass++;
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_bypass();
      logic [68:0] e;
      drive(1'b1, 32'h80, 32'h00108113, 1'b1, 1'b0);
      #1;
      e = exp_vec();
      n_checks++;
`ifdef RVSEED_IFQ_BYPASS_EN
      if (obs !== e || out_valid !== 1'b1 || out_pc !== 32'h80 || count !== 3'd0)
`else
      if (obs !== e || out_valid !== 1'b0)
`endif
         $display("FAIL bypass_cycle obs=%h exp=%h", obs, e);
      else n_pass++;
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      e = exp_vec();
      n_checks++;
      if (obs !== e) $display("FAIL bypass_next obs=%h exp=%h", obs, e);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic [68:0] e;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, $urandom,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
         #1;
         e = exp_vec();
         n_checks++;
         if (obs !== e) $display("FAIL random[%0d] obs=%h exp=%h", i, obs, e);
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_bypass();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Small FIFO directly downstream of the fetch stage (PC register, next-PC mux, instruction memory).
- Captures each fetched {pc, inst} pair and presents it to decode over a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered entries on a redirect (taken branch/jump) flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- XLEN, 32, PC width
- ILEN, 32, instruction width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- flush  in  1  synchronous discard of all entries (redirect from branch/jump)
- in_valid  in  1  fetch presents a valid pc/inst pair
- in_ready  out  1  queue can accept; = !full
- in_pc  in  XLEN  PC of fetched instruction
- in_inst  in  ILEN  fetched instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head entry
- out_inst  out  ILEN  instruction of head entry
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH x {pc, inst}.
  - wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - empty = ptrs equal; full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, storage=0. Outputs: count=0, out_valid=0, in_ready=1, out_pc=0, out_inst=0.
- push = in_valid & in_ready & !flush. On push, write mem[wr_ptr] and increment wr_ptr.
- pop = out_valid & out_ready & !flush. On pop, increment rd_ptr.
- Push and pop in the same cycle: both occur; count unchanged.
- Full: in_ready=0. in_valid is ignored, and fetch must hold its data.
  - No same-cycle push-on-pop when full (in_ready has no combinational dependence on out_ready).
- Empty: out_valid=0, out_pc=0, out_inst=0. out_ready is ignored.
- out_valid = !empty. out_pc/out_inst = mem[rd_ptr] (combinational read of head).
- Latency: entry pushed in cycle N is visible at the outputs in cycle N+1.
- Flush: on the next edge, wr_ptr and rd_ptr are both set to the current rd_ptr value, giving count=0.
  - Flush has priority over push and pop; the incoming entry that cycle is dropped.
  - Storage contents are not cleared.
- Flush while empty: no effect.
- Order is strictly FIFO. No entry is duplicated or lost except on flush.
- Reset asserted mid-operation: immediate return to the reset state regardless of handshakes in flight.
- count = wr_ptr - rd_ptr (modulo pointer width).

Optional Feature:
- Macro: RVSEED_IFQ_BYPASS_EN.
- Defined: when empty and !flush:
  - out_valid = in_valid; out_pc/out_inst = in_pc/in_inst (combinational pass-through).
  - If out_ready is also 1, the entry is consumed directly and not written (pointers unchanged).
  - If out_ready is 0, it is written normally.
  - Zero-cycle latency through an empty queue.
- Undefined: outputs are driven only from storage; 1-cycle minimum latency.

Decomposition:
- Defines in rvseed_defines.v: XLEN/ILEN defaults, the NOP encoding 32'h0000_0013 (used by decode on !out_valid), and the bypass macro guard.
- One natural sub-module, ifq_ptr: pointer register with increment, flush-load and full/empty compare, instantiated twice (wr and rd).

Test Plan:
- Reset, then push pc=0x0,0x4,0x8,0xC (inst=0x00000013,0x00500093,0x00108113,0x002081B3) with out_ready=0 -> count=4, in_ready=0; a 5th push with pc=0x10 is not accepted.
- Then drain with out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles with matching insts; final count=0, out_valid=0.
- Continuous push+pop for 20 cycles, pc from 0x100 step 4 -> count constant at 1, out_pc lags in_pc by one cycle, pointers wrap with no loss.
- Fill 3 entries, assert flush with in_valid=1 pc=0x40 -> next cycle count=0, out_valid=0; pc 0x40 is never emitted.
- Assert rst asynchronously mid-cycle with count=2 -> outputs reset immediately; after release, the first push pc=0x200 appears with count=1.
- With RVSEED_IFQ_BYPASS_EN, empty queue, in_valid=1 pc=0x80, out_ready=1 -> out_valid=1 and out_pc=0x80 the same cycle; count stays 0.
  - Without the macro: out_valid=0 that cycle, then 0x80 on the next cycle.
